// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : shift_pkg
//  Purpose    : Constants and helpers shared by the serializing transmitter
//               and the serial word receiver (direction names, counter
//               width helper).
//  Ports      : none (package)
//  Revision   : 1.0  initial release
// ============================================================================
package shift_pkg;

  localparam string DIR_LEFT  = "LEFT";
  localparam string DIR_RIGHT = "RIGHT";

  // ceil(log2(value)), but never less than one bit so a W=1 counter still
  // has a legal vector width.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage : shift_pkg
`default_nettype wire

// File: rtl/sipo_shift_stage.sv
`default_nettype none
// ============================================================================
//  Module     : sipo_shift_stage
//  Purpose    : Serial-in shift register plus bit counter. Reports the
//               assembled word (including the bit sampled this edge) and a
//               done strobe on the edge that completes a word.
//  Ports      : clock, aclr_n, sclr      - clock / async clear / sync clear
//               shift_en_i               - sample shiftin_i this edge
//               restart_i                - this bit is bit 0 of a new word
//               shiftin_i                - serial data bit
//               word_o                   - word as it will be after this edge
//               done_o                   - this edge completes a word
//  Revision   : 1.0  initial release
// ============================================================================
module sipo_shift_stage
  import shift_pkg::*;
#(
  parameter int    SHIFT_WIDTH     = 8,
  parameter string SHIFT_DIRECTION = "LEFT"
) (
  input  logic                   clock,
  input  logic                   aclr_n,
  input  logic                   sclr,
  input  logic                   shift_en_i,
  input  logic                   restart_i,
  input  logic                   shiftin_i,
  output logic [SHIFT_WIDTH-1:0] word_o,
  output logic                   done_o
);

  localparam int CNT_W = clog2_min1(SHIFT_WIDTH);

  logic [SHIFT_WIDTH-1:0] sh_q, sh_d, shifted;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   done;

  generate
    if (SHIFT_WIDTH == 1) begin : g_w1
      assign shifted = shiftin_i;
    end else if (SHIFT_DIRECTION == DIR_RIGHT) begin : g_right
      assign shifted = {shiftin_i, sh_q[SHIFT_WIDTH-1:1]};
    end else begin : g_left
      assign shifted = {sh_q[SHIFT_WIDTH-2:0], shiftin_i};
    end
  endgenerate

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    done  = 1'b0;
    if (shift_en_i) begin
      sh_d = shifted;
      if (restart_i) begin
        // Resync: stale partial bits are shifted out by the time the new
        // word completes, so only the counter needs forcing.
        if (SHIFT_WIDTH == 1) begin
          done  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = CNT_W'(1);
        end
      end else if (cnt_q == CNT_W'(SHIFT_WIDTH - 1)) begin
        done  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (sclr) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign word_o = shifted;
  assign done_o = done;

endmodule : sipo_shift_stage
`default_nettype wire

// File: rtl/serial_word_receiver.sv
`default_nettype none
// ============================================================================
//  Module     : serial_word_receiver
//  Purpose    : Serial-in/parallel-out receiver with frame arming, a
//               valid/ready output register and sticky overrun detection.
//  Ports      : clock, aclr_n, sclr      - clock / async clear / sync clear
//               enable                   - bit strobe
//               shiftin, frame_start     - serial data and word marker
//               data_ready               - consumer accept
//               data_out, data_valid     - completed word and its valid
//               overrun                  - sticky dropped-word flag
//  Revision   : 1.0  initial release
// ============================================================================
module serial_word_receiver
  import shift_pkg::*;
#(
  parameter int    SHIFT_WIDTH     = 8,
  parameter string SHIFT_DIRECTION = "LEFT"
) (
  input  logic                   clock,
  input  logic                   aclr_n,
  input  logic                   sclr,
  input  logic                   enable,
  input  logic                   shiftin,
  input  logic                   frame_start,
  input  logic                   data_ready,
  output logic [SHIFT_WIDTH-1:0] data_out,
  output logic                   data_valid,
  output logic                   overrun
);

  logic                   armed_q, armed_d;
  logic [SHIFT_WIDTH-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ovr_q, ovr_d;
  logic                   shift_en, restart, done;
  logic [SHIFT_WIDTH-1:0] word;

  assign restart  = enable & frame_start;
  assign shift_en = enable & (armed_q | frame_start);

  sipo_shift_stage #(
    .SHIFT_WIDTH     (SHIFT_WIDTH),
    .SHIFT_DIRECTION (SHIFT_DIRECTION)
  ) u_stage (
    .clock      (clock),
    .aclr_n     (aclr_n),
    .sclr       (sclr),
    .shift_en_i (shift_en),
    .restart_i  (restart),
    .shiftin_i  (shiftin),
    .word_o     (word),
    .done_o     (done)
  );

  always_comb begin
    armed_d = armed_q | restart;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (!valid_q) begin
      if (done) begin
        data_d  = word;
        valid_d = 1'b1;
      end
    end else if (data_ready) begin
      // Accept and refill in the same edge keeps valid high.
      if (done) begin
        data_d = word;
      end else begin
        valid_d = 1'b0;
      end
    end else if (done) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      armed_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (sclr) begin
      armed_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      armed_q <= armed_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign overrun    = ovr_q;

endmodule : serial_word_receiver
`default_nettype wire

// File: tb/tb_serial_word_receiver.sv
`default_nettype none
// ============================================================================
//  Module     : tb_serial_word_receiver
//  Purpose    : Directed self-checking bench for serial_word_receiver, with
//               one LEFT and one RIGHT instance sharing the same stimulus.
//  Revision   : 1.0  initial release
// ============================================================================
module tb_serial_word_receiver;

  logic       clock = 1'b0;
  logic       aclr_n, sclr, enable, shiftin, frame_start, data_ready;
  logic [7:0] data_l, data_r;
  logic       valid_l, valid_r, ovr_l, ovr_r;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  serial_word_receiver #(.SHIFT_WIDTH(8), .SHIFT_DIRECTION("LEFT")) dut_l (
    .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .enable(enable),
    .shiftin(shiftin), .frame_start(frame_start), .data_ready(data_ready),
    .data_out(data_l), .data_valid(valid_l), .overrun(ovr_l)
  );

  serial_word_receiver #(.SHIFT_WIDTH(8), .SHIFT_DIRECTION("RIGHT")) dut_r (
    .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .enable(enable),
    .shiftin(shiftin), .frame_start(frame_start), .data_ready(data_ready),
    .data_out(data_r), .data_valid(valid_r), .overrun(ovr_r)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One enabled bit; returns #1 after the sampling edge.
  task automatic send_bit(input logic b, input logic fs);
    @(negedge clock);
    enable      = 1'b1;
    shiftin     = b;
    frame_start = fs;
    @(posedge clock);
    #1;
  endtask

  // MSB-first word, optionally with frame_start on its first bit.
  task automatic send_word(input logic [7:0] w, input logic fs);
    for (int i = 7; i >= 0; i--) send_bit(w[i], fs && (i == 7));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      enable      = 1'b0;
      frame_start = 1'b0;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_sclr;
    @(negedge clock);
    enable = 1'b0; frame_start = 1'b0; sclr = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    sclr = 1'b0;
  endtask

  logic [7:0] tx;

  initial begin
    aclr_n = 1'b0; sclr = 1'b0; enable = 1'b0; shiftin = 1'b0;
    frame_start = 1'b0; data_ready = 1'b1;
    #12;
    check("rst_data", data_l, 8'h00);
    check("rst_valid", valid_l, 1'b0);
    check("rst_ovr", ovr_l, 1'b0);
    @(negedge clock);
    aclr_n = 1'b1;

    // Bits before arming are ignored.
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
    check("unarmed_valid", valid_l, 1'b0);

    // Basic word, both directions; valid for exactly one cycle.
    send_word(8'hCC, 1'b1);
    check("left_cc_valid", valid_l, 1'b1);
    check("left_cc_data", data_l, 8'hCC);
    check("right_33_data", data_r, 8'h33);
    idle(1);
    check("left_valid_drop", valid_l, 1'b0);
    check("left_data_kept", data_l, 8'hCC);

    // Overrun with consumer stalled.
    pulse_sclr();
    data_ready = 1'b0;
    send_word(8'hCC, 1'b1);
    check("ovr_first_valid", valid_l, 1'b1);
    send_word(8'hA5, 1'b0);
    check("ovr_data_kept", data_l, 8'hCC);
    check("ovr_flag", ovr_l, 1'b1);
    check("ovr_flag_r", ovr_r, 1'b1);
    @(negedge clock);
    data_ready = 1'b1;
    idle(1);
    check("ovr_valid_drop", valid_l, 1'b0);
    check("ovr_sticky", ovr_l, 1'b1);
    pulse_sclr();
    check("sclr_ovr", ovr_l, 1'b0);
    check("sclr_data", data_l, 8'h00);

    // Accept and refill on the same edge.
    data_ready = 1'b0;
    send_word(8'h0F, 1'b1);
    for (int i = 7; i >= 1; i--) send_bit(i[0] ? 1'b1 : 1'b1, 1'b0);
    @(negedge clock);
    enable = 1'b1; shiftin = 1'b0; frame_start = 1'b0; data_ready = 1'b1;
    @(posedge clock);
    #1;
    check("refill_data", data_l, 8'hFE);
    check("refill_valid", valid_l, 1'b1);
    check("refill_ovr", ovr_l, 1'b0);
    pulse_sclr();
    data_ready = 1'b0;
    send_word(8'h0F, 1'b1);
    for (int i = 7; i >= 1; i--) send_bit(8'hF0 >> i, 1'b0);
    @(negedge clock);
    enable = 1'b1; shiftin = 1'b0; data_ready = 1'b1;
    @(posedge clock);
    #1;
    check("b2b_f0_data", data_l, 8'hF0);
    check("b2b_f0_valid", valid_l, 1'b1);
    check("b2b_f0_ovr", ovr_l, 1'b0);
    idle(1);

    // Resync mid-word.
    for (int i = 0; i < 5; i++) send_bit(i[0], i == 0);
    check("partial_no_valid", valid_l, 1'b0);
    send_word(8'h81, 1'b1);
    check("resync_data", data_l, 8'h81);
    check("resync_data_r", data_r, 8'h81);
    check("resync_valid", valid_l, 1'b1);
    idle(1);

    // Async clear mid-word disarms.
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    @(negedge clock);
    aclr_n = 1'b0;
    #1;
    check("aclr_data", data_l, 8'h00);
    check("aclr_valid", valid_l, 1'b0);
    @(negedge clock);
    aclr_n = 1'b1;
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
    check("aclr_disarmed", valid_l, 1'b0);
    send_word(8'h5A, 1'b1);
    check("rearm_data", data_l, 8'h5A);
    check("rearm_data_r", data_r, 8'h5A);
    idle(1);

    // Loopback from an MSB-first serializer loaded with 8'hCC.
    tx = 8'hCC;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      enable = 1'b1; shiftin = tx[7]; frame_start = (i == 0);
      @(posedge clock);
      #1;
      tx = {tx[6:0], 1'b0};
    end
    check("loop_data", data_l, 8'hCC);
    check("loop_valid", valid_l, 1'b1);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_word_receiver
`default_nettype wire
